// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM state
// encodings, register word offsets, CTRL field positions and the MODE value
// that selects auto-reload.
package timer_pkg;

    // Countdown FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Word offsets within the device window (addr[3:2] of the byte address)
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL field positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    // MODE encoding that selects auto-reload; anything else is one-shot
    localparam logic [1:0] MODE_AUTO_DEFAULT = 2'd1;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer. Three word registers (CTRL, PRESET, COUNT),
// a four-state countdown FSM and a zero-latency read mux. A bus write to
// CTRL or PRESET pre-empts the FSM for that edge: it returns the FSM to IDLE,
// clears the pending interrupt and leaves COUNT untouched.
module timer_dev
    import timer_pkg::*;
#(
    parameter int         CNT_W     = 32,
    parameter logic [1:0] MODE_AUTO = MODE_AUTO_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    timer_state_e        state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q,  ctrl_d;
    logic [CNT_W-1:0]    preset_q, preset_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                irq_q,   irq_d;

    logic                wr_ctrl_s;
    logic                wr_preset_s;
    logic                auto_mode_s;
    logic                unused_addr_s;

    // Only the word offset inside the device window is decoded
    assign unused_addr_s = ^addr[29:2];

    assign wr_ctrl_s   = WE && (addr[1:0] == OFF_CTRL);
    assign wr_preset_s = WE && (addr[1:0] == OFF_PRESET);
    assign auto_mode_s = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

    // Interrupt mask only gates the output; the flag itself runs regardless
    assign IRQ = irq_q & ctrl_q[CTRL_IM];

    // State and register file, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= {CTRL_W{1'b0}};
            preset_q <= CNT_ZERO;
            count_q  <= CNT_ZERO;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    // Next-state logic: bus writes to CTRL/PRESET take priority over the FSM
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;

        if (wr_ctrl_s || wr_preset_s) begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
            if (wr_ctrl_s) begin
                ctrl_d = Din[CTRL_W-1:0];
            end else begin
                preset_d = Din[CNT_W-1:0];
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_q[CTRL_EN]) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    count_d = preset_q;
                    state_d = ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_q[CTRL_EN]) begin
                        state_d = ST_IDLE;
                    end else if (count_q > CNT_ONE) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        // Terminal count; never decrement below zero
                        count_d = CNT_ZERO;
                        irq_d   = 1'b1;
                        state_d = ST_INT;
                    end
                end
                ST_INT: begin
                    // Auto-reload keeps EN so IDLE re-enters LOAD next cycle
                    if (auto_mode_s) begin
                        irq_d = 1'b0;
                    end else begin
                        ctrl_d[CTRL_EN] = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Zero-latency read mux; the unused offset reads zero
    always_comb begin
        Dout = 32'h0000_0000;
        case (addr[1:0])
            OFF_CTRL:   Dout = {{(32-CTRL_W){1'b0}}, ctrl_q};
            OFF_PRESET: Dout = preset_q;
            OFF_COUNT:  Dout = count_q;
            default:    Dout = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev. Inputs change on the falling
// edge and outputs are sampled just after it, so "after edge t+k" means the
// k-th falling edge following the write edge t.
module tb_timer_dev;
    import timer_pkg::*;

    logic        clk;
    logic        reset;
    logic [29:0] addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
        addr = {28'd0, off};
        #1;
        chk(tag, Dout, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        chk(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Single-cycle bus write; returns at the falling edge after the write edge
    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        addr = {28'd0, off};
        Din  = data;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
        Din  = 32'd0;
    endtask

    logic [31:0] exp_cnt;

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        addr  = 30'd0;
        Din   = 32'd0;
        tick(2);

        // Reset state
        rd_chk("rst_ctrl",   OFF_CTRL,   32'h0);
        rd_chk("rst_preset", OFF_PRESET, 32'h0);
        rd_chk("rst_count",  OFF_COUNT,  32'h0);
        irq_chk("rst_irq", 1'b0);
        reset = 1'b0;
        tick(1);

        // 1. Reset mid-count
        wr(OFF_PRESET, 32'd5);
        wr(OFF_CTRL, 32'h9);
        tick(2);
        rd_chk("t1_count5", OFF_COUNT, 32'd5);
        reset = 1'b1;
        #1;
        irq_chk("t1_async_irq", 1'b0);
        rd_chk("t1_async_ctrl",   OFF_CTRL,   32'h0);
        rd_chk("t1_async_preset", OFF_PRESET, 32'h0);
        rd_chk("t1_async_count",  OFF_COUNT,  32'h0);
        tick(1);
        reset = 1'b0;
        tick(3);
        rd_chk("t1_idle_count", OFF_COUNT, 32'h0);
        rd_chk("t1_idle_ctrl",  OFF_CTRL,  32'h0);
        irq_chk("t1_idle_irq", 1'b0);

        // 2. One-shot, PRESET=4, CTRL=0x9: COUNT 4,3,2,1,0 after t+2..t+6
        wr(OFF_PRESET, 32'd4);
        wr(OFF_CTRL, 32'h9);
        tick(1);
        for (int k = 2; k <= 6; k++) begin
            tick(1);
            rd_chk($sformatf("t2_count_k%0d", k), OFF_COUNT, 32'(6 - k));
            irq_chk($sformatf("t2_irq_k%0d", k), (k == 6));
        end
        tick(1);
        rd_chk("t2_ctrl_en_clr", OFF_CTRL, 32'h8);
        irq_chk("t2_irq_held_a", 1'b1);
        tick(2);
        irq_chk("t2_irq_held_b", 1'b1);
        rd_chk("t2_count_zero", OFF_COUNT, 32'h0);
        wr(OFF_CTRL, 32'h0);
        irq_chk("t2_irq_cleared", 1'b0);
        rd_chk("t2_ctrl_zero", OFF_CTRL, 32'h0);

        // 3. Auto-reload, PRESET=3, CTRL=0xB: IRQ pulses after t+5, t+11, t+17
        wr(OFF_PRESET, 32'd3);
        wr(OFF_CTRL, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            tick(1);
            if (k < 2) begin
                exp_cnt = 32'd0;
            end else begin
                case ((k - 2) % 6)
                    0:       exp_cnt = 32'd3;
                    1:       exp_cnt = 32'd2;
                    2:       exp_cnt = 32'd1;
                    default: exp_cnt = 32'd0;
                endcase
            end
            irq_chk($sformatf("t3_irq_k%0d", k), (k == 5) || (k == 11) || (k == 17));
            rd_chk($sformatf("t3_count_k%0d", k), OFF_COUNT, exp_cnt);
            rd_chk($sformatf("t3_ctrl_k%0d", k), OFF_CTRL, 32'hB);
        end
        wr(OFF_CTRL, 32'h0);
        irq_chk("t3_stop_irq", 1'b0);

        // 4. IM=0: PRESET=2, CTRL=0x1
        wr(OFF_PRESET, 32'd2);
        wr(OFF_CTRL, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            irq_chk($sformatf("t4_irq_k%0d", k), 1'b0);
            if (k == 2) rd_chk("t4_count_k2", OFF_COUNT, 32'd2);
            if (k == 4) rd_chk("t4_count_k4", OFF_COUNT, 32'd0);
            if (k == 5) rd_chk("t4_ctrl_k5", OFF_CTRL, 32'h0);
        end

        // 5. Pause at COUNT=7, then retrigger from a new PRESET
        wr(OFF_PRESET, 32'd9);
        wr(OFF_CTRL, 32'h1);
        tick(4);
        rd_chk("t5_count7", OFF_COUNT, 32'd7);
        wr(OFF_CTRL, 32'h0);
        tick(3);
        rd_chk("t5_hold7", OFF_COUNT, 32'd7);
        wr(OFF_PRESET, 32'd10);
        rd_chk("t5_hold7_preset", OFF_COUNT, 32'd7);
        wr(OFF_CTRL, 32'h1);
        tick(2);
        rd_chk("t5_restart10", OFF_COUNT, 32'd10);
        tick(1);
        rd_chk("t5_next9", OFF_COUNT, 32'd9);
        wr(OFF_CTRL, 32'h0);

        // 6. Bus edge cases
        wr(OFF_COUNT, 32'h55);
        rd_chk("t6_count_ro", OFF_COUNT, 32'd9);
        wr(2'd3, 32'hAA);
        rd_chk("t6_off3_zero", 2'd3, 32'h0);
        rd_chk("t6_count_ro2", OFF_COUNT, 32'd9);
        rd_chk("t6_preset_kept", OFF_PRESET, 32'd10);
        wr(OFF_CTRL, 32'hFFFF_FFFF);
        rd_chk("t6_ctrl_mask", OFF_CTRL, 32'hF);
        wr(OFF_CTRL, 32'h0);

        // Write landing on the INT cycle beats the FSM EN clear
        wr(OFF_PRESET, 32'd2);
        wr(OFF_CTRL, 32'h9);
        tick(4);
        irq_chk("t6_int_irq", 1'b1);
        wr(OFF_CTRL, 32'h9);
        rd_chk("t6_int_override", OFF_CTRL, 32'h9);
        irq_chk("t6_int_irq_clr", 1'b0);
        tick(2);
        rd_chk("t6_int_restart", OFF_COUNT, 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
